id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state on posedge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: flush  in  1  discard held entry.
REQ-004 SHALL have: in_valid  in  1; in_ready  out  1; instr  in  32; rs_data  in  32; rt_data  in  32 (register-file values, same cycle as instr).
REQ-005 SHALL have: out_valid  out  1; out_ready  in  1; alu_a  out  32; alu_b  out  32; aluc  out  4; rd_addr  out  5; wr_en  out  1; illegal  out  1.
REQ-006 SHALL have: illegal_cnt  out  16  saturating count of accepted illegal instructions.

Function
REQ-007 SHALL decode MIPS-32 words into ALU operands/opcode and hold them in a one-entry output register.
REQ-008 SHALL use aluc encoding: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 1000, SLT 1010, SLTU 1011, SRA 1100, SRL 1101, SLL 1110.
REQ-009 SHALL decode R-type (op 0x00) funct 0x20-0x27, 0x2A, 0x2B, 0x00, 0x02, 0x03; I-type op 0x08,0x09,0x0A,0x0B,0x0C,0x0D,0x0E,0x0F.
REQ-010 SHALL set, for R-type non-shift: alu_a=rs_data, alu_b=rt_data, rd_addr=instr[15:11].
REQ-011 SHALL set, for immediate shifts: alu_a={27'b0,shamt}, alu_b=rt_data (shift amount on a, value on b).
REQ-012 SHALL set, for I-type: alu_a=rs_data, alu_b=imm, rd_addr=instr[20:16]; andi/ori/xori zero-extend, others sign-extend.
REQ-013 SHALL set, for lui: alu_a=0, alu_b={16'b0,imm}, aluc=LUI.
REQ-014 SHALL force wr_en=0 when rd_addr==0; otherwise wr_en=1 for legal instructions.
REQ-015 SHALL, for undecodable words: illegal=1, wr_en=0, aluc=0000, alu_a=alu_b=0; entry still delivered through handshake.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-017 SHALL capture on in_valid && in_ready; outputs valid exactly one cycle later; latency 1, full throughput.
REQ-018 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid after out_ready handshake with no simultaneous capture; simultaneous drain+capture replaces entry without bubble.
REQ-020 SHALL give flush priority: out_valid=0 next cycle, concurrent input dropped, illegal_cnt not incremented for it.
REQ-021 SHALL increment illegal_cnt on capture of illegal word, saturating at 0xFFFF.

Reset
REQ-022 SHALL on rst: out_valid=0, alu_a=alu_b=0, aluc=0000, rd_addr=0, wr_en=0, illegal=0, illegal_cnt=0.
REQ-023 SHALL drop held entry on rst mid-transfer; rst dominates flush and capture.

Configuration
REQ-024 SHALL use macro SHIFT_VAR_EN: defined -> decode sllv/srlv/srav (funct 0x04/0x06/0x07) with alu_a=rs_data, alu_b=rt_data, aluc SLL/SRL/SRA.
REQ-025 SHALL, without SHIFT_VAR_EN, treat funct 0x04/0x06/0x07 as illegal per REQ-015.

Structure
REQ-026 SHALL place aluc constants, opcode and funct constants in shared package mips_pkg, also used by the ALU.
REQ-027 SHALL split combinational decode into sub-module id_decode; id_stage holds handshake register and counter.

Verification
REQ-028 add 0x00221820, rs_data=5, rt_data=7 -> next cycle aluc=0010, a=5, b=7, rd_addr=3, wr_en=1.
REQ-029 sll 0x000220C0, rt_data=0x1 -> a=3, b=0x1, aluc=1110, rd_addr=4.
REQ-030 addi 0x2022FFFF -> b=0xFFFFFFFF, aluc=0010, rd_addr=2; ori 0x3422FFFF -> b=0x0000FFFF, aluc=0101.
REQ-031 out_ready=0 for 3 cycles after capture -> outputs stable, in_ready=0; out_ready=1 with new in_valid -> back-to-back, no bubble.
REQ-032 sllv 0x00431004, rs_data=4 -> with SHIFT_VAR_EN a=4, aluc=1110; without -> illegal=1, wr_en=0, illegal_cnt=1.
REQ-033 flush asserted with in_valid=1 and entry held -> out_valid=0 next cycle, illegal_cnt unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg -- shared MIPS-32 decode constants for the ID stage and the ALU.
//   aluc_t   : 4-bit ALU operation code consumed by the ALU
//   OP_* / F_*: primary opcode and R-type funct field values
//   dec_t    : decoded operand bundle handed from id_decode to id_stage
package mips_pkg;

   typedef enum logic [3:0] {
      ALUC_ADDU = 4'b0000,
      ALUC_SUBU = 4'b0001,
      ALUC_ADD  = 4'b0010,
      ALUC_SUB  = 4'b0011,
      ALUC_AND  = 4'b0100,
      ALUC_OR   = 4'b0101,
      ALUC_XOR  = 4'b0110,
      ALUC_NOR  = 4'b0111,
      ALUC_LUI  = 4'b1000,
      ALUC_SLT  = 4'b1010,
      ALUC_SLTU = 4'b1011,
      ALUC_SRA  = 4'b1100,
      ALUC_SRL  = 4'b1101,
      ALUC_SLL  = 4'b1110
   } aluc_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef struct packed {
      logic [31:0] alu_a;
      logic [31:0] alu_b;
      aluc_t       aluc;
      logic [4:0]  rd_addr;
      logic        wr_en;
      logic        illegal;
   } dec_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/id_decode.sv
// id_decode -- combinational MIPS-32 decoder feeding the ID stage register.
//   i_instr   : instruction word
//   i_rs_data : register-file value for rs
//   i_rt_data : register-file value for rt
//   o_dec     : decoded ALU operands, aluc, destination, wr_en, illegal flag
// Build option: SHIFT_VAR_EN enables sllv/srlv/srav; without it they decode
// as illegal.
module id_decode
   import mips_pkg::*;
(
   input  logic [31:0] i_instr,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   output dec_t        o_dec
);

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_shamt;
   logic [4:0]  w_rd;
   logic [4:0]  w_rt;
   logic [15:0] w_imm;
   logic        w_unused_rs;

   assign w_op        = i_instr[31:26];
   assign w_funct     = i_instr[5:0];
   assign w_shamt     = i_instr[10:6];
   assign w_rd        = i_instr[15:11];
   assign w_rt        = i_instr[20:16];
   assign w_imm       = i_instr[15:0];
   // rs index is resolved by the register file upstream; only its data arrives here
   assign w_unused_rs = ^i_instr[25:21];

   always_comb begin
      o_dec         = '0;
      // I-type defaults; the R-type branch overrides destination and operand b
      o_dec.alu_a   = i_rs_data;
      o_dec.rd_addr = w_rt;
      case (w_op)
         OP_RTYPE: begin
            o_dec.alu_b   = i_rt_data;
            o_dec.rd_addr = w_rd;
            case (w_funct)
               F_ADD:  o_dec.aluc = ALUC_ADD;
               F_ADDU: o_dec.aluc = ALUC_ADDU;
               F_SUB:  o_dec.aluc = ALUC_SUB;
               F_SUBU: o_dec.aluc = ALUC_SUBU;
               F_AND:  o_dec.aluc = ALUC_AND;
               F_OR:   o_dec.aluc = ALUC_OR;
               F_XOR:  o_dec.aluc = ALUC_XOR;
               F_NOR:  o_dec.aluc = ALUC_NOR;
               F_SLT:  o_dec.aluc = ALUC_SLT;
               F_SLTU: o_dec.aluc = ALUC_SLTU;
               // immediate shifts: shift amount on a, value on b
               F_SLL: begin o_dec.aluc = ALUC_SLL; o_dec.alu_a = {27'b0, w_shamt}; end
               F_SRL: begin o_dec.aluc = ALUC_SRL; o_dec.alu_a = {27'b0, w_shamt}; end
               F_SRA: begin o_dec.aluc = ALUC_SRA; o_dec.alu_a = {27'b0, w_shamt}; end
`ifdef SHIFT_VAR_EN
               F_SLLV: o_dec.aluc = ALUC_SLL;
               F_SRLV: o_dec.aluc = ALUC_SRL;
               F_SRAV: o_dec.aluc = ALUC_SRA;
`endif
               default: o_dec.illegal = 1'b1;
            endcase
         end
         OP_ADDI:  begin o_dec.aluc = ALUC_ADD;  o_dec.alu_b = sext16(w_imm); end
         OP_ADDIU: begin o_dec.aluc = ALUC_ADDU; o_dec.alu_b = sext16(w_imm); end
         OP_SLTI:  begin o_dec.aluc = ALUC_SLT;  o_dec.alu_b = sext16(w_imm); end
         OP_SLTIU: begin o_dec.aluc = ALUC_SLTU; o_dec.alu_b = sext16(w_imm); end
         OP_ANDI:  begin o_dec.aluc = ALUC_AND;  o_dec.alu_b = {16'b0, w_imm}; end
         OP_ORI:   begin o_dec.aluc = ALUC_OR;   o_dec.alu_b = {16'b0, w_imm}; end
         OP_XORI:  begin o_dec.aluc = ALUC_XOR;  o_dec.alu_b = {16'b0, w_imm}; end
         OP_LUI: begin
            o_dec.aluc  = ALUC_LUI;
            o_dec.alu_a = 32'b0;
            o_dec.alu_b = {16'b0, w_imm};
         end
         default: o_dec.illegal = 1'b1;
      endcase

      if (o_dec.illegal) begin
         o_dec         = '0;
         o_dec.illegal = 1'b1;
      end else begin
         o_dec.wr_en = (o_dec.rd_addr != 5'd0);
      end
   end

endmodule

// File: rtl/id_stage.sv
// id_stage -- MIPS-32 instruction decode stage with a one-entry output register.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop the held entry and any concurrent input
//   in_valid/in_ready   : upstream handshake; instr, rs_data, rt_data
//   out_valid/out_ready : downstream handshake
//   alu_a, alu_b, aluc, rd_addr, wr_en, illegal : registered decode result
//   illegal_cnt         : saturating count of accepted illegal words
// Build option: SHIFT_VAR_EN (see id_decode) enables variable shifts.
module id_stage
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  aluc,
   output logic [4:0]  rd_addr,
   output logic        wr_en,
   output logic        illegal,
   output logic [15:0] illegal_cnt
);

   dec_t        w_dec;
   logic        w_capture;
   logic        r_valid;
   dec_t        r_dec;
   logic [15:0] r_cnt;

   id_decode u_decode (
      .i_instr   (instr),
      .i_rs_data (rs_data),
      .i_rt_data (rt_data),
      .o_dec     (w_dec)
   );

   assign in_ready  = !r_valid || out_ready;
   assign w_capture = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_dec   <= '0;
         r_cnt   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid <= 1'b1;
         r_dec   <= w_dec;
         if (w_dec.illegal && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid   = r_valid;
   assign alu_a       = r_dec.alu_a;
   assign alu_b       = r_dec.alu_b;
   assign aluc        = r_dec.aluc;
   assign rd_addr     = r_dec.rd_addr;
   assign wr_en       = r_dec.wr_en;
   assign illegal     = r_dec.illegal;
   assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

`ifdef SHIFT_VAR_EN
   localparam bit VAR_EN = 1'b1;
`else
   localparam bit VAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instr, rs_data, rt_data, alu_a, alu_b;
   logic [3:0]  aluc;
   logic [4:0]  rd_addr;
   logic        wr_en, illegal;
   logic [15:0] illegal_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  aluc;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t        m;
   bit          m_valid;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc), .rd_addr(rd_addr),
      .wr_en(wr_en), .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decode from the instruction-set table: opcode/funct -> operation code.
   function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      exp_t        e;
      bit          ok;
      int          op, fn, k;
      int          itype_code [8];
      logic [31:0] shamt, imm_s, imm_z;
      itype_code = '{2, 0, 10, 11, 4, 5, 6, 8}; // ops 0x08..0x0F
      op    = int'(ins[31:26]);
      fn    = int'(ins[5:0]);
      shamt = {27'b0, ins[10:6]};
      imm_s = {{16{ins[15]}}, ins[15:0]};
      imm_z = {16'b0, ins[15:0]};
      e  = '0;
      ok = 1'b1;
      if (op == 0) begin
         e.a  = rs;
         e.b  = rt;
         e.rd = ins[15:11];
         case (fn)
            'h20: e.aluc = 4'd2;   'h21: e.aluc = 4'd0;
            'h22: e.aluc = 4'd3;   'h23: e.aluc = 4'd1;
            'h24: e.aluc = 4'd4;   'h25: e.aluc = 4'd5;
            'h26: e.aluc = 4'd6;   'h27: e.aluc = 4'd7;
            'h2A: e.aluc = 4'd10;  'h2B: e.aluc = 4'd11;
            'h00: begin e.aluc = 4'd14; e.a = shamt; end
            'h02: begin e.aluc = 4'd13; e.a = shamt; end
            'h03: begin e.aluc = 4'd12; e.a = shamt; end
            'h04: if (VAR_EN) e.aluc = 4'd14; else ok = 1'b0;
            'h06: if (VAR_EN) e.aluc = 4'd13; else ok = 1'b0;
            'h07: if (VAR_EN) e.aluc = 4'd12; else ok = 1'b0;
            default: ok = 1'b0;
         endcase
      end else if (op >= 8 && op <= 15) begin
         k      = op - 8;
         e.aluc = 4'(itype_code[k]);
         e.rd   = ins[20:16];
         e.a    = (op == 15) ? 32'd0 : rs;
         e.b    = (op >= 12) ? imm_z : imm_s;
      end else begin
         ok = 1'b0;
      end
      if (!ok) begin
         e     = '0;
         e.ill = 1'b1;
      end else begin
         e.we = (e.rd != 5'd0);
      end
      return e;
   endfunction

   // One clock: drive, check in_ready, clock, advance model, check outputs.
   task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] rsd,
                       input logic [31:0] rtd, input bit ordy, input bit fl, input bit r);
      bit acc;
      in_valid  = iv;  instr = ins; rs_data = rsd; rt_data = rtd;
      out_ready = ordy; flush = fl; rst = r;
      #1;
      if (!r) chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
      acc = iv && (!m_valid || ordy);
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0; m = '0; m_cnt = '0;
      end else if (fl) begin
         m_valid = 1'b0;
      end else if (acc) begin
         m_valid = 1'b1;
         m = ref_dec(ins, rsd, rtd);
         if (m.ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      #1;
      chk("out_valid",   32'(out_valid),   32'(m_valid));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
      chk("alu_a",       alu_a,            m.a);
      chk("alu_b",       alu_b,            m.b);
      chk("aluc",        32'(aluc),        32'(m.aluc));
      chk("rd_addr",     32'(rd_addr),     32'(m.rd));
      chk("wr_en",       32'(wr_en),       32'(m.we));
      chk("illegal",     32'(illegal),     32'(m.ill));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          fsel [17];
      fsel = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B,
               'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h3F};
      w = $urandom;
      case ($urandom_range(0, 3))
         0: begin w[31:26] = 6'h00; w[5:0] = 6'(fsel[$urandom_range(0, 16)]); end
         1: w[31:26] = 6'($urandom_range(8, 15));
         2: w[31:26] = 6'h0F;
         default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
         w[15:11] = 5'd0;
         w[20:16] = 5'd0;
      end
      return w;
   endfunction

   logic [31:0] hold_a, hold_b;
   logic [3:0]  hold_aluc;

   initial begin
      m = '0; m_valid = 1'b0; m_cnt = '0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = '0; rs_data = '0; rt_data = '0;
      @(posedge clk); #1;
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);

      // add $3,$1,$2
      step(1, 32'h00221820, 32'd5, 32'd7, 1, 0, 0);
      chk("add_aluc", 32'(aluc), 32'h2);
      chk("add_a", alu_a, 32'd5);
      chk("add_b", alu_b, 32'd7);
      chk("add_rd", 32'(rd_addr), 32'd3);
      chk("add_we", 32'(wr_en), 32'd1);

      // sll $4,$2,3
      step(1, 32'h000220C0, 32'hDEAD0000, 32'h1, 1, 0, 0);
      chk("sll_a", alu_a, 32'd3);
      chk("sll_b", alu_b, 32'h1);
      chk("sll_aluc", 32'(aluc), 32'hE);
      chk("sll_rd", 32'(rd_addr), 32'd4);

      step(1, 32'h2022FFFF, 32'h10, 32'h20, 1, 0, 0);
      chk("addi_b", alu_b, 32'hFFFFFFFF);
      chk("addi_aluc", 32'(aluc), 32'h2);
      chk("addi_rd", 32'(rd_addr), 32'd2);
      step(1, 32'h3422FFFF, 32'h10, 32'h20, 1, 0, 0);
      chk("ori_b", alu_b, 32'h0000FFFF);
      chk("ori_aluc", 32'(aluc), 32'h5);

      // backpressure: hold for 3 cycles then drain+capture with no bubble
      step(1, 32'h00221820, 32'd11, 32'd22, 1, 0, 0);
      hold_a = alu_a; hold_b = alu_b; hold_aluc = aluc;
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h00221822, 32'd99, 32'd88, 0, 0, 0);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_a", alu_a, hold_a);
         chk("stall_b", alu_b, hold_b);
         chk("stall_aluc", 32'(aluc), 32'(hold_aluc));
      end
      step(1, 32'h00221822, 32'd99, 32'd88, 1, 0, 0);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_aluc", 32'(aluc), 32'h3);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // sllv $2,$3,$2 from a clean counter
      step(0, 0, 0, 0, 1, 0, 1);
      step(1, 32'h00431004, 32'd4, 32'h55, 1, 0, 0);
      if (VAR_EN) begin
         chk("sllv_a", alu_a, 32'd4);
         chk("sllv_aluc", 32'(aluc), 32'hE);
      end else begin
         chk("sllv_ill", 32'(illegal), 32'd1);
         chk("sllv_we", 32'(wr_en), 32'd0);
         chk("sllv_cnt", 32'(illegal_cnt), 32'd1);
      end

      // flush with a held entry and an illegal word offered
      step(1, 32'h00221820, 32'd1, 32'd2, 0, 0, 0);
      step(1, 32'hFC000000, 32'd1, 32'd2, 0, 1, 0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_cnt", 32'(illegal_cnt), VAR_EN ? 32'd0 : 32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(bit'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
              bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 19) == 0),
              bit'($urandom_range(0, 299) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
